// File: rtl/fpmul_issue_ctrl.sv
// Issue sequencer for the FP32 multiplier: latches one FMUL.S request, strobes the operands in,
// waits for a fresh result strobe (or times out and resets the multiplier) and holds a tagged writeback.
module fpmul_issue_ctrl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_rd,
  output logic             stall,
  output logic [31:0]      mul_a,
  output logic             mul_a_stb,
  output logic [31:0]      mul_b,
  output logic             mul_b_stb,
  input  logic [31:0]      mul_z,
  input  logic             mul_z_stb,
  output logic             mul_rst_n,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT,
    S_WB,
    S_RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [TAG_W-1:0] wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_err_q, wb_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             rec_q, rec_d;

  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    rec_d     = rec_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mul_a_d = req_a;
          mul_b_d = req_b;
          wb_rd_d = req_rd;
          armed_d = 1'b0;
          state_d = S_SEND_A;
        end
      end
      S_SEND_A: begin
        armed_d = armed_q | ~mul_z_stb;
        state_d = S_SEND_B;
      end
      S_SEND_B: begin
        armed_d = armed_q | ~mul_z_stb;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A strobe only counts once it has been seen low during this operation.
        if (armed_q && mul_z_stb) begin
          wb_data_d = mul_z;
          wb_err_d  = 1'b0;
          state_d   = S_WB;
        end else begin
          armed_d = armed_q | ~mul_z_stb;
          if (cnt_q == CNT_LAST) begin
            rec_d   = 1'b0;
            state_d = S_RECOVER;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RECOVER: begin
        if (rec_q) begin
          wb_data_d = CANON_NAN;
          wb_err_d  = 1'b1;
          state_d   = S_WB;
        end else begin
          rec_d = 1'b1;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          wb_err_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      rec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      rec_q     <= rec_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign stall     = (state_q != S_IDLE);
  assign mul_a_stb = (state_q == S_SEND_A);
  assign mul_b_stb = (state_q == S_SEND_B);
  assign wb_valid  = (state_q == S_WB);
  // The multiplier shares our reset and is additionally held in reset during recovery.
  assign mul_rst_n = ~rst & (state_q != S_RECOVER);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
// Self-checking bench for fpmul_issue_ctrl: a transaction-level model predicts, from the strobe
// schedule fed to the multiplier side, when and what each writeback should be.
module tb_fpmul_issue_ctrl;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_rd = '0;
  logic             stall;
  logic [31:0]      mul_a;
  logic             mul_a_stb;
  logic [31:0]      mul_b;
  logic             mul_b_stb;
  logic [31:0]      mul_z = '0;
  logic             mul_z_stb = 1'b0;
  logic             mul_rst_n;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [TAG_W-1:0] wb_rd;
  logic [31:0]      wb_data;
  logic             wb_err;

  int total = 0;
  int bad   = 0;

  fpmul_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .stall(stall),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb),
    .mul_rst_n(mul_rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Result strobe level in cycle k after the transfer: leftover high for 'stale' cycles,
  // then low until 'hit' (hit < 0 means the multiplier never answers).
  function automatic bit stb_at(input int k, input int stale, input int hit);
    return (k < stale) || (hit >= 0 && k >= hit);
  endfunction

  // One operation, cycle k=0 is the transfer cycle. The model finds the first WAIT cycle
  // (k = 3 .. TIMEOUT+2) where the strobe is high after having been low in some cycle since k=1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] rd,
                        input int stale, input int hit, input int bp,
                        input logic [31:0] res, input logic [31:0] old, input bit noise);
    int acc = -1;
    bit low_seen = 1'b0;
    int w, end_k;
    logic [31:0] exp_data;
    logic exp_err, exp_rdy, exp_wbv, exp_rstn;
    int wb_seen = 0;
    for (int c = 1; c <= TIMEOUT + 2; c++) begin
      if (acc < 0 && c >= 3 && stb_at(c, stale, hit) && low_seen) acc = c;
      if (!stb_at(c, stale, hit)) low_seen = 1'b1;
    end
    w        = (acc >= 0) ? acc + 1 : TIMEOUT + 5;
    exp_data = (acc >= 0) ? res : 32'h7FC0_0000;
    exp_err  = (acc < 0);
    end_k    = w + bp;
    for (int k = 0; k <= end_k + 1; k++) begin
      @(negedge clk);
      exp_rdy  = (k == 0) || (k > end_k);
      exp_wbv  = (k >= w) && (k <= end_k);
      exp_rstn = !(acc < 0 && (k == TIMEOUT + 3 || k == TIMEOUT + 4));
      total++;
      if (req_ready !== exp_rdy || stall !== !exp_rdy) begin
        bad++;
        $display("FAIL handshake k=%0d req_ready=%b stall=%b required req_ready=%b", k, req_ready, stall, exp_rdy);
      end
      total++;
      if (mul_a_stb !== (k == 1) || mul_b_stb !== (k == 2)) begin
        bad++;
        $display("FAIL strobes k=%0d a_stb=%b b_stb=%b required %b %b", k, mul_a_stb, mul_b_stb, k == 1, k == 2);
      end
      total++;
      if (mul_rst_n !== exp_rstn) begin
        bad++;
        $display("FAIL mul_rst_n k=%0d got=%b required=%b", k, mul_rst_n, exp_rstn);
      end
      total++;
      if (wb_valid !== exp_wbv) begin
        bad++;
        $display("FAIL wb_valid k=%0d got=%b required=%b", k, wb_valid, exp_wbv);
      end
      if (exp_wbv) begin
        wb_seen++;
        total++;
        if (wb_rd !== rd || wb_data !== exp_data || wb_err !== exp_err) begin
          bad++;
          $display("FAIL wb_payload k=%0d rd=%0d data=%h err=%b required rd=%0d data=%h err=%b",
                   k, wb_rd, wb_data, wb_err, rd, exp_data, exp_err);
        end
      end
      if (k >= 1) begin
        total++;
        if (mul_a !== a || mul_b !== b) begin
          bad++;
          $display("FAIL operands k=%0d mul_a=%h mul_b=%h required %h %h", k, mul_a, mul_b, a, b);
        end
      end
      // Drive this cycle's inputs.
      if (k == 0) begin
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_rd = rd;
      end else begin
        req_valid = noise && (k <= end_k) && ($urandom_range(0, 1) == 1);
        req_a = $urandom;
        req_b = $urandom;
        req_rd = TAG_W'($urandom);
      end
      mul_z_stb = stb_at(k, stale, hit);
      mul_z = (k < stale) ? old : res;
      if (k >= w && k < end_k) wb_ready = 1'b0;
      else if (k == end_k) wb_ready = 1'b1;
      else wb_ready = ($urandom_range(0, 1) == 1);
    end
    req_valid = 1'b0;
    $display("op rd=%0d a=%h b=%h data=%h err=%b wb_cycles=%0d", rd, a, b, exp_data, exp_err, wb_seen);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mul_rst_n !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl mul_rst_n=%b stall=%b req_ready=%b wb_valid=%b required 0 0 1 0",
               mul_rst_n, stall, req_ready, wb_valid);
    end
    total++;
    if (mul_a !== 32'h0 || mul_b !== 32'h0 || wb_data !== 32'h0 || wb_rd !== '0 || wb_err !== 1'b0
        || mul_a_stb !== 1'b0 || mul_b_stb !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs mul_a=%h mul_b=%h wb_data=%h wb_rd=%0d wb_err=%b required all zero",
               mul_a, mul_b, wb_data, wb_rd, wb_err);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mul_rst_n !== 1'b1 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release mul_rst_n=%b req_ready=%b required 1 1", mul_rst_n, req_ready);
    end
  endtask

  task automatic test_basic();
    run_op(32'h4000_0000, 32'h4040_0000, 5'd7, 0, 12, 0, 32'h40C0_0000, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Strobe still high from the previous op must not be taken as this op's result.
    run_op(32'h3F80_0000, 32'hC000_0000, 5'd3, 5, 9, 0, 32'hC000_0000, 32'h40C0_0000, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(32'h4100_0000, 32'h3F00_0000, 5'd12, 0, 4, 5, 32'h4080_0000, 32'hC000_0000, 1'b1);
  endtask

  task automatic test_timeout();
    run_op(32'h4040_0000, 32'h4040_0000, 5'd9, 0, -1, 2, 32'h4110_0000, 32'h0, 1'b0);
    run_op(32'h4080_0000, 32'h4000_0000, 5'd10, 0, 7, 0, 32'h4100_0000, 32'h0, 1'b0);
  endtask

  task automatic test_same_cycle();
    run_op(32'h3FC0_0000, 32'h4000_0000, 5'd21, 0, TIMEOUT + 2, 1, 32'h4040_0000, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_a = 32'h4120_0000;
    req_b = 32'h4120_0000;
    req_rd = 5'd30;
    mul_z_stb = 1'b0;
    wb_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || wb_valid !== 1'b0 || mul_rst_n !== 1'b0 || req_ready !== 1'b1
        || mul_a !== 32'h0 || wb_data !== 32'h0 || wb_rd !== '0) begin
      bad++;
      $display("FAIL async_reset stall=%b wb_valid=%b mul_rst_n=%b req_ready=%b mul_a=%h required 0 0 0 1 0",
               stall, wb_valid, mul_rst_n, req_ready, mul_a);
    end
    mul_z_stb = 1'b1;
    mul_z = 32'h42C8_0000;
    for (int k = 0; k < 3; k++) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0 || req_ready !== 1'b1 || mul_rst_n !== 1'b1) begin
        bad++;
        $display("FAIL post_reset_idle wb_valid=%b req_ready=%b mul_rst_n=%b required 0 1 1",
                 wb_valid, req_ready, mul_rst_n);
      end
    end
    run_op(32'h4000_0000, 32'h4080_0000, 5'd4, 2, 6, 0, 32'h4100_0000, 32'h42C8_0000, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] prev = 32'h42C8_0000;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      logic [31:0] r = a ^ {b[15:0], b[31:16]};
      int stale = $urandom_range(0, 6);
      int hit = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 20);
      run_op(a, b, TAG_W'($urandom), stale, hit, $urandom_range(0, 4), r, prev, 1'b1);
      prev = r;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
